// File: rtl/io_write_arbiter_if.sv
// io_write_arbiter_if: request/grant bundle between the IO write-path
// requesters and the arbiter that owns the mux select lines.
interface io_write_arbiter_if;
    logic       Arb_Enable;
    logic [3:0] Req;
    logic [3:0] Done;
    logic       Beat_Valid;
    logic [3:0] Grant;
    logic       Write_Files;
    logic       File_Type;
    logic       Write_Layer;
    logic       Busy;
    logic       Abort;

    modport master (
        output Arb_Enable,
        output Req,
        output Done,
        output Beat_Valid,
        input  Grant,
        input  Write_Files,
        input  File_Type,
        input  Write_Layer,
        input  Busy,
        input  Abort
    );

    modport slave (
        input  Arb_Enable,
        input  Req,
        input  Done,
        input  Beat_Valid,
        output Grant,
        output Write_Files,
        output File_Type,
        output Write_Layer,
        output Busy,
        output Abort
    );
endinterface

// File: rtl/io_write_arbiter.sv
// io_write_arbiter: round-robin IO write-path arbiter with burst lock
// and a one-cycle turnaround gap between grants.
module io_write_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    io_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(MAX_BURST);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [2:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       gidx_q, gidx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;

    logic             win_vld;
    logic [1:0]       win_idx;
    logic             end_burst;

    // Mux select code for each requester; 000 is reserved for idle.
    function automatic logic [2:0] sel_code(input logic [1:0] idx);
        logic [2:0] code;
        unique case (idx)
            2'd0:    code = 3'b100;
            2'd1:    code = 3'b110;
            2'd2:    code = 3'b011;
            default: code = 3'b001;
        endcase
        return code;
    endfunction

    // Round-robin search: first set request at or above the pointer, mod 4.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.Req[ptr_q + 2'(i)]) begin
                win_vld = 1'b1;
                win_idx = ptr_q + 2'(i);
            end
        end
    end

    // Next-state logic; grant and select are computed here so they
    // leave the register on the same edge.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        cnt_d     = cnt_q;
        abort_d   = 1'b0;
        end_burst = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Arb_Enable && win_vld) begin
                    state_d = S_GRANT;
                    gidx_d  = win_idx;
                    grant_d = 4'b0001 << win_idx;
                    sel_d   = sel_code(win_idx);
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (!bus.Req[gidx_q]) begin
                    end_burst = 1'b1;
                    abort_d   = 1'b1;
                end else if (bus.Done[gidx_q]) begin
                    end_burst = 1'b1;
                end else if (bus.Beat_Valid && cnt_q == LAST) begin
                    end_burst = 1'b1;
                end
                if (bus.Beat_Valid && cnt_q != SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (end_burst) begin
                    state_d = S_GAP;
                    grant_d = 4'b0000;
                    sel_d   = 3'b000;
                    ptr_d   = gidx_q + 2'd1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 4'b0000;
                sel_d   = 3'b000;
            end
        endcase
    end

    // State and output registers; reset drops the path immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 3'b000;
            ptr_q   <= 2'd0;
            gidx_q  <= 2'd0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    assign bus.Grant       = grant_q;
    assign bus.Write_Files = sel_q[2];
    assign bus.File_Type   = sel_q[1];
    assign bus.Write_Layer = sel_q[0];
    assign bus.Busy        = (state_q == S_GRANT);
    assign bus.Abort       = abort_q;

endmodule
